mdu: RTL and testbench
======================

// Module: mdu
// PURPOSE
// - Parametrised multi-cycle multiply/divide unit for the pipelined MIPS core; sits in EX beside alu.
// - Owns HI/LO registers; executes MULT/MULTU/DIV/DIVU with configurable latency, plus MTHI/MTLO.
// - Raises busy so hazard control stalls mfhi/mflo/md instructions until result commits.
// PARAMETERS
// - WIDTH       32  operand and HI/LO width
// - MUL_CYCLES  5   multiply latency in cycles (>=1)
// - DIV_CYCLES  10  divide latency in cycles (>=1)
// PORTS
// - clk    in   1      single clock, rising edge
// - reset  in   1      asynchronous, active-high; clears all state
// - start  in   1      op strobe, sampled on clk rising edge
// - MDop   in   3      operation (encodings in mdu_pkg)
// - SrcA   in   WIDTH  rs operand (dividend / multiplicand / MT data)
// - SrcB   in   WIDTH  rt operand (divisor / multiplier)
// - busy   out  1      operation in flight
// - HI     out  WIDTH  HI register
// - LO     out  WIDTH  LO register
// BEHAVIOUR
// - Reset (async, active-high): HI=0, LO=0, busy=0, counter=0, FSM->IDLE; in-flight op discarded, never commits.
// - FSM: IDLE, BUSY. IDLE+start+MULT/MULTU/DIV/DIVU -> BUSY, operands latched, counter=latency-1.
// - BUSY: counter decrements each cycle; at counter==0 the edge commits HI/LO, FSM->IDLE, busy->0.
// - Timing: start sampled at edge k -> busy=1 from just after edge k until edge k+N; HI/LO new
//   after edge k+N (N=MUL_CYCLES or DIV_CYCLES). HI/LO hold old values throughout BUSY.
// - Back-to-back: start accepted in cycle after busy falls (busy is registered; no same-edge restart).
// - start while BUSY: ignored entirely (any op incl. MTHI/MTLO); control guarantees no issue, bench checks ignore.
// - MTHI/MTLO in IDLE: single-cycle, HI (or LO) = SrcA at that edge; busy stays 0.
// - MDop NOP or unused encodings: no effect.
// - MULT: signed WIDTHxWIDTH -> 2*WIDTH; HI=upper, LO=lower. MULTU: unsigned, same split.
// - DIV: signed, quotient truncates toward zero -> LO; remainder takes sign of dividend -> HI.
// - DIVU: unsigned quotient -> LO, remainder -> HI.
// - Divide by zero (DIV or DIVU): full latency still elapses; LO=all ones, HI=SrcA.
// - Signed overflow (DIV, SrcA=most-negative, SrcB=-1): LO=most-negative, HI=0.
// - Arithmetic may be computed from latched operands at any point; only commit timing is architectural.
// - Operands latched at start; SrcA/SrcB changes during BUSY have no effect.
// STRUCTURE
// - mdu_pkg: MDop encodings (MD_NOP=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6),
//   FSM state typedef, latency width helper (clog2 of max latency).
// - Sub-module mdu_div_core: combinational signed/unsigned divide with div-by-zero/overflow fixups;
//   multiply inline. FSM, counter, operand and HI/LO registers in mdu top.
// TESTING
// - MULT SrcA=-3 (0xFFFFFFFD), SrcB=7 -> busy 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
// - MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after edge k+5; HI/LO unchanged before.
// - DIV -7/2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1), busy exactly 10 cycles; DIVU 7/2 -> LO=3, HI=1.
// - DIV 0x80000000/-1 -> LO=0x80000000, HI=0; DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
// - MTHI 0x1234 then MULT issued while BUSY with MTLO pulse -> MTLO ignored, MULT result commits normally.
// - reset asserted mid-DIV (cycle 4) -> HI=LO=0, busy=0 immediately; no commit after release; new op works.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared definitions for the multiply/divide unit. It holds the
//               MDop encodings, the FSM state type and the helper that sizes
//               the latency counter.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // Operation encodings carried on MDop
    localparam logic [2:0] MD_NOP   = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Counter width needed to hold (max latency - 1). A latency of 1 still
    // needs at least one bit so that the counter signal exists.
    function automatic int cnt_width(input int mul_cycles, input int div_cycles);
        int mx;
        mx = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
        return (mx <= 1) ? 1 : $clog2(mx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_if
// Description : Issue/result bundle between the EX stage and the MDU. The
//               master issues operations and the slave (mdu) returns busy
//               and HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       MDop;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, MDop, SrcA, SrcB,
        input  busy, HI, LO
    );

    modport slave (
        input  start, MDop, SrcA, SrcB,
        output busy, HI, LO
    );
endinterface
`default_nettype wire

// File: rtl/mdu_div_core.sv
`default_nettype none
// ============================================================================
// Module      : mdu_div_core
// Description : Combinational signed/unsigned divider. It fixes up the
//               MIPS-defined results for divide-by-zero and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] i_dividend,
    input  wire logic [WIDTH-1:0] i_divisor,
    input  wire logic             i_signed,
    output logic      [WIDTH-1:0] o_quo,
    output logic      [WIDTH-1:0] o_rem
);
    localparam logic [WIDTH-1:0] c_most_neg = {1'b1, {(WIDTH-1){1'b0}}};

    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_uquo;
    logic [WIDTH-1:0] w_urem;

    // Divide magnitudes unsigned, then restore the signs. The quotient
    // truncates toward zero and the remainder follows the dividend.
    assign w_neg_a = i_signed & i_dividend[WIDTH-1];
    assign w_neg_b = i_signed & i_divisor[WIDTH-1];
    assign w_abs_a = w_neg_a ? (~i_dividend + 1'b1) : i_dividend;
    assign w_abs_b = w_neg_b ? (~i_divisor + 1'b1) : i_divisor;
    assign w_uquo  = (i_divisor == '0) ? '0 : (w_abs_a / w_abs_b);
    assign w_urem  = (i_divisor == '0) ? '0 : (w_abs_a % w_abs_b);

    // Sign restoration followed by the architectural special cases
    always_comb begin
        o_quo = (w_neg_a ^ w_neg_b) ? (~w_uquo + 1'b1) : w_uquo;
        o_rem = w_neg_a ? (~w_urem + 1'b1) : w_urem;
        if (i_divisor == '0) begin
            o_quo = '1;
            o_rem = i_dividend;
        end else if (i_signed && (i_dividend == c_most_neg) && (i_divisor == '1)) begin
            o_quo = c_most_neg;
            o_rem = '0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module      : mdu
// Description : Multi-cycle multiply/divide unit. It owns HI/LO and runs
//               MULT/MULTU/DIV/DIVU with a fixed latency. MTHI and MTLO
//               complete in a single cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input wire logic clk,
    input wire logic reset,
    mdu_if.slave     bus
);
    localparam int                 c_cnt_w    = cnt_width(MUL_CYCLES, DIV_CYCLES);
    localparam logic [c_cnt_w-1:0] c_mul_last = c_cnt_w'(MUL_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(DIV_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q,   cnt_d;
    logic [2:0]         op_q,    op_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;
    logic [WIDTH-1:0]   hi_q,    hi_d;
    logic [WIDTH-1:0]   lo_q,    lo_d;

    logic               w_is_mul;
    logic               w_mul_signed;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_hi_res;
    logic [WIDTH-1:0]   w_lo_res;

    // Product from latched operands. The low 2*WIDTH bits of a product of
    // sign-extended values equal the signed product, so one multiplier
    // serves both MULT and MULTU.
    assign w_is_mul     = (op_q == MD_MULT) || (op_q == MD_MULTU);
    assign w_mul_signed = (op_q == MD_MULT);
    assign w_ext_a      = {{WIDTH{w_mul_signed & a_q[WIDTH-1]}}, a_q};
    assign w_ext_b      = {{WIDTH{w_mul_signed & b_q[WIDTH-1]}}, b_q};
    assign w_prod       = w_ext_a * w_ext_b;

    mdu_div_core #(
        .WIDTH      (WIDTH)
    ) u_div_core (
        .i_dividend (a_q),
        .i_divisor  (b_q),
        .i_signed   (op_q == MD_DIV),
        .o_quo      (w_quo),
        .o_rem      (w_rem)
    );

    assign w_hi_res = w_is_mul ? w_prod[2*WIDTH-1:WIDTH] : w_rem;
    assign w_lo_res = w_is_mul ? w_prod[WIDTH-1:0]       : w_quo;

    // Next-state logic: accept ops only in IDLE. In BUSY, count down and
    // commit HI/LO on the edge where the counter has reached zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.MDop)
                        MD_MULT, MD_MULTU: begin
                            state_d = ST_BUSY;
                            cnt_d   = c_mul_last;
                            op_d    = bus.MDop;
                            a_d     = bus.SrcA;
                            b_d     = bus.SrcB;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_d = ST_BUSY;
                            cnt_d   = c_div_last;
                            op_d    = bus.MDop;
                            a_d     = bus.SrcA;
                            b_d     = bus.SrcB;
                        end
                        MD_MTHI: hi_d = bus.SrcA;
                        MD_MTLO: lo_d = bus.SrcA;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    hi_d    = w_hi_res;
                    lo_d    = w_lo_res;
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand and HI/LO registers. Reset discards any op in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_NOP;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = (state_q == ST_BUSY);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu
// Description : Directed self-checking bench for mdu with hand-computed
//               HI/LO results and busy timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam int         NMUL     = 5;
    localparam int         NDIV     = 10;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mdu_if #(.WIDTH(32)) bus ();

    mdu #(
        .WIDTH      (32),
        .MUL_CYCLES (NMUL),
        .DIV_CYCLES (NDIV)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one multi-cycle op. Check that busy stays high for exactly n
    // sampled cycles with HI/LO held, then check the committed result.
    // With disturb set, an MTLO strobe and new operands are driven while busy.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit disturb);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        old_hi = bus.HI;
        old_lo = bus.LO;
        @(negedge clk);
        bus.start = 1'b1;
        bus.MDop  = op;
        bus.SrcA  = a;
        bus.SrcB  = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.MDop  = OP_NOP;
        bus.SrcA  = 32'hA5A5_A5A5;
        bus.SrcB  = 32'h0000_0003;
        for (int i = 0; i < n; i++) begin
            chk({name, " busy"}, {31'd0, bus.busy}, 32'd1);
            chk({name, " hi_hold"}, bus.HI, old_hi);
            chk({name, " lo_hold"}, bus.LO, old_lo);
            if (disturb && i == 1) begin
                bus.start = 1'b1;
                bus.MDop  = OP_MTLO;
                bus.SrcA  = 32'hDEAD_BEEF;
            end else if (disturb && i == 2) begin
                bus.start = 1'b0;
                bus.MDop  = OP_NOP;
            end
            @(negedge clk);
        end
        chk({name, " busy_done"}, {31'd0, bus.busy}, 32'd0);
        chk({name, " HI"}, bus.HI, exp_hi);
        chk({name, " LO"}, bus.LO, exp_lo);
    endtask

    // Single-cycle op issued in IDLE (MTHI/MTLO/NOP/unused encodings)
    task automatic quick_op(input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        bus.start = 1'b1;
        bus.MDop  = op;
        bus.SrcA  = a;
        bus.SrcB  = 32'h0000_0009;
        @(negedge clk);
        bus.start = 1'b0;
        bus.MDop  = OP_NOP;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.MDop  = OP_NOP;
        bus.SrcA  = '0;
        bus.SrcB  = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        chk("rst HI", bus.HI, 32'd0);
        chk("rst LO", bus.LO, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("mult", OP_MULT, 32'hFFFF_FFFD, 32'd7, NMUL, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NMUL, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, NDIV, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, NDIV, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, NDIV, 32'd1, 32'd3, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, NDIV, 32'd0, 32'h8000_0000, 1'b0);
        run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, NDIV, 32'd5, 32'hFFFF_FFFF, 1'b0);
        run_op("div_by0", OP_DIV, 32'hFFFF_FFF0, 32'd0, NDIV, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0);

        // MTHI completes in one cycle and leaves LO alone
        quick_op(OP_MTHI, 32'h0000_1234);
        chk("mthi busy", {31'd0, bus.busy}, 32'd0);
        chk("mthi HI", bus.HI, 32'h0000_1234);
        chk("mthi LO", bus.LO, 32'hFFFF_FFFF);

        // NOP and the unused encoding change nothing
        quick_op(OP_NOP, 32'h5555_5555);
        quick_op(3'd7, 32'h6666_6666);
        chk("nop busy", {31'd0, bus.busy}, 32'd0);
        chk("nop HI", bus.HI, 32'h0000_1234);
        chk("nop LO", bus.LO, 32'hFFFF_FFFF);

        // MULT with an MTLO strobe and operand changes while busy
        run_op("mult_dist", OP_MULT, 32'd6, 32'd7, NMUL, 32'd0, 32'd42, 1'b1);

        quick_op(OP_MTLO, 32'h0000_5678);
        chk("mtlo LO", bus.LO, 32'h0000_5678);
        chk("mtlo HI", bus.HI, 32'd0);

        // Reset asserted during the fourth busy cycle of a DIV
        @(negedge clk);
        bus.start = 1'b1;
        bus.MDop  = OP_DIV;
        bus.SrcA  = 32'd100;
        bus.SrcB  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.MDop  = OP_NOP;
        repeat (3) @(negedge clk);
        chk("pre_rst busy", {31'd0, bus.busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst HI", bus.HI, 32'd0);
        chk("mid_rst LO", bus.LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (NDIV + 3) @(negedge clk);
        chk("post_rst busy", {31'd0, bus.busy}, 32'd0);
        chk("post_rst HI", bus.HI, 32'd0);
        chk("post_rst LO", bus.LO, 32'd0);

        run_op("divu_after", OP_DIVU, 32'd100, 32'd7, NDIV, 32'd2, 32'd14, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so a stuck design still terminates
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
